// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage_pkg
//  Brief   : Shared widths and FSM state encoding for the memory-access stage.
//  Revision: 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;

   // Data-memory access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/reg_memory_writeback.sv
`default_nettype none
// ============================================================================
//  Module  : reg_memory_writeback
//  Brief   : MEM/WB pipeline register; loads only when the stage is not stalled.
//  Revision: 1.0 - initial release
// ============================================================================
module reg_memory_writeback
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [XLEN-1:0]       readdata_in,
   input  logic [XLEN-1:0]       aluresult_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  regwrite_in,
   input  logic                  memtoreg_in,
   output logic [XLEN-1:0]       wb_readdata,
   output logic [XLEN-1:0]       wb_aluresult,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_regwrite,
   output logic                  wb_memtoreg
);

   // Capture the stage results whenever the pipeline advances
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_readdata  <= '0;
         wb_aluresult <= '0;
         wb_rd        <= '0;
         wb_regwrite  <= 1'b0;
         wb_memtoreg  <= 1'b0;
      end else if (en) begin
         wb_readdata  <= readdata_in;
         wb_aluresult <= aluresult_in;
         wb_rd        <= rd_in;
         wb_regwrite  <= regwrite_in;
         wb_memtoreg  <= memtoreg_in;
      end
   end

endmodule : reg_memory_writeback
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module  : memory_access_stage
//  Brief   : Pipeline MEM stage: sequences data-memory requests with a
//            req/ack handshake, stalls upstream while an access is pending,
//            resolves branches and feeds the MEM/WB register.
//  Revision: 1.0 - initial release
// ============================================================================
module memory_access_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   // EX/MEM register contents
   input  logic [XLEN-1:0]       Adderout,
   input  logic                  zero,
   input  logic [XLEN-1:0]       result_out_alu,
   input  logic [XLEN-1:0]       writedata_out,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  Branch,
   input  logic                  Memread,
   input  logic                  Memtoreg,
   input  logic                  Memwrite,
   input  logic                  Regwrite,
   input  logic                  addermuxselect,
   // Data-memory port
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [XLEN-1:0]       dmem_addr,
   output logic [XLEN-1:0]       dmem_wdata,
   input  logic [XLEN-1:0]       dmem_rdata,
   input  logic                  dmem_ack,
   // Pipeline control
   output logic                  stall,
   output logic                  pcsrc,
   output logic [XLEN-1:0]       branch_target,
   // MEM/WB register
   output logic [XLEN-1:0]       wb_readdata,
   output logic [XLEN-1:0]       wb_aluresult,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_regwrite,
   output logic                  wb_memtoreg
);

   mem_state_t      r_state;
   logic [XLEN-1:0] r_load;
   logic            w_mem_op;
   logic            w_is_read;
   logic            w_stall;
   logic [XLEN-1:0] w_wb_readdata;

   // A set Memwrite wins over Memread, so "read" means read-only
   assign w_mem_op  = Memread | Memwrite;
   assign w_is_read = Memread & ~Memwrite;

   // Stall from the cycle the op is seen until its ack; released in DONE.
   // Gated by reset so an abandoned access frees the pipeline immediately.
   assign w_stall = reset & (((r_state == ST_IDLE) & w_mem_op) | (r_state == ST_ACCESS));
   assign stall   = w_stall;

   // Branch resolution; a redirect is suppressed while the stage is held
   assign pcsrc         = Branch & zero & ~w_stall;
   assign branch_target = addermuxselect ? result_out_alu : Adderout;

   // Loads return the captured data, every other instruction returns zero
   assign w_wb_readdata = w_is_read ? r_load : '0;

   // Access sequencer with registered memory-port outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_load     <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mem_op) begin
                  r_state    <= ST_ACCESS;
                  dmem_req   <= 1'b1;
                  dmem_we    <= Memwrite;
                  dmem_addr  <= result_out_alu;
                  dmem_wdata <= writedata_out;
               end
            end
            ST_ACCESS: begin
               if (dmem_ack) begin
                  r_state    <= ST_DONE;
                  dmem_req   <= 1'b0;
                  dmem_we    <= 1'b0;
                  dmem_wdata <= '0;
                  if (!dmem_we) begin
                     r_load <= dmem_rdata;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state  <= ST_IDLE;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
            end
         endcase
      end
   end

   reg_memory_writeback #(
      .XLEN (XLEN)
   ) u_reg_memory_writeback (
      .clk          (clk),
      .reset        (reset),
      .en           (~w_stall),
      .readdata_in  (w_wb_readdata),
      .aluresult_in (result_out_alu),
      .rd_in        (rd),
      .regwrite_in  (Regwrite),
      .memtoreg_in  (Memtoreg),
      .wb_readdata  (wb_readdata),
      .wb_aluresult (wb_aluresult),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .wb_memtoreg  (wb_memtoreg)
   );

endmodule : memory_access_stage
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_memory_access_stage
//  Brief   : Scoreboard bench for memory_access_stage with a memory responder
//            and an instruction-level reference model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_memory_access_stage;

   logic        clk;
   logic        reset;
   logic [63:0] Adderout, result_out_alu, writedata_out;
   logic        zero, Branch, Memread, Memtoreg, Memwrite, Regwrite, addermuxselect;
   logic [4:0]  rd;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        stall, pcsrc;
   logic [63:0] branch_target, wb_readdata, wb_aluresult;
   logic [4:0]  wb_rd;
   logic        wb_regwrite, wb_memtoreg;

   memory_access_stage #(.XLEN(64)) dut (
      .clk(clk), .reset(reset),
      .Adderout(Adderout), .zero(zero), .result_out_alu(result_out_alu),
      .writedata_out(writedata_out), .rd(rd),
      .Branch(Branch), .Memread(Memread), .Memtoreg(Memtoreg),
      .Memwrite(Memwrite), .Regwrite(Regwrite), .addermuxselect(addermuxselect),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
      .wb_readdata(wb_readdata), .wb_aluresult(wb_aluresult), .wb_rd(wb_rd),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic [63:0] wdata;
      int          d;
   } acc_t;

   typedef struct {
      logic [63:0] rdata;
      logic [63:0] alu;
      logic [4:0]  rd;
      logic        rw;
      logic        mtr;
   } wb_t;

   acc_t        acc_q[$];
   wb_t         wb_q[$];
   logic [63:0] mem_arr [16];   // memory seen by the responder
   logic [63:0] ref_mem [16];   // model's own view of memory
   int          total = 0;
   int          bad   = 0;
   logic        mon_on  = 1'b0;
   logic        resp_on = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: every edge where the stage was not stalled retires one instruction
   initial begin
      logic en;
      wb_t  e;
      forever begin
         @(negedge clk);
         en = mon_on && (reset === 1'b1) && (stall === 1'b0);
         @(posedge clk);
         #2;
         if (en) begin
            if (wb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL wb_unexpected: got update want none");
            end else begin
               e = wb_q.pop_front();
               chk("wb_readdata",  wb_readdata,  e.rdata);
               chk("wb_aluresult", wb_aluresult, e.alu);
               chk("wb_rd",        {59'd0, wb_rd}, {59'd0, e.rd});
               chk("wb_regwrite",  {63'd0, wb_regwrite}, {63'd0, e.rw});
               chk("wb_memtoreg",  {63'd0, wb_memtoreg}, {63'd0, e.mtr});
            end
         end
      end
   end

   // Memory responder: checks each request, holds it for d cycles, then acks
   initial begin
      acc_t a;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (resp_on && dmem_req === 1'b1) begin
            if (acc_q.size() == 0) begin
               total++; bad++;
               $display("FAIL dmem_unexpected: got req want none");
               a = '{dmem_addr, dmem_we, dmem_wdata, 0};
            end else begin
               a = acc_q.pop_front();
            end
            chk("dmem_addr",  dmem_addr, a.addr);
            chk("dmem_we",    {63'd0, dmem_we}, {63'd0, a.we});
            if (a.we) chk("dmem_wdata", dmem_wdata, a.wdata);
            for (int k = 0; k < a.d; k++) begin
               @(negedge clk);
               chk("dmem_req_held", {63'd0, dmem_req}, 64'd1);
               chk("dmem_addr_held", dmem_addr, a.addr);
            end
            dmem_ack = 1'b1;
            if (dmem_we) begin
               dmem_rdata = {$urandom, $urandom};
               mem_arr[dmem_addr[6:3]] = dmem_wdata;
            end else begin
               dmem_rdata = mem_arr[dmem_addr[6:3]];
            end
            @(negedge clk);
            dmem_ack = 1'b0;
         end
      end
   end

   // Presents one instruction and holds it until the stage accepts it
   task automatic issue(input logic [4:0] i_rd, input logic [63:0] alu, input logic [63:0] adder,
                        input logic [63:0] wdata, input logic br, input logic zr, input logic mr,
                        input logic mtr, input logic mw, input logic rw, input logic ams,
                        input int d);
      int          cnt;
      int          exp_cnt;
      logic        s;
      logic        memop;
      logic [63:0] rdv;
      acc_t        a;
      wb_t         w;
      rd = i_rd; result_out_alu = alu; Adderout = adder; writedata_out = wdata;
      Branch = br; zero = zr; Memread = mr; Memtoreg = mtr; Memwrite = mw;
      Regwrite = rw; addermuxselect = ams;
      memop = mr | mw;
      rdv = '0;
      if (mr && !mw) rdv = ref_mem[alu[6:3]];
      if (mw) ref_mem[alu[6:3]] = wdata;
      if (memop) begin
         a = '{alu, mw, wdata, d};
         acc_q.push_back(a);
      end
      w = '{rdv, alu, i_rd, rw, mtr};
      wb_q.push_back(w);
      exp_cnt = memop ? 3 + d : 1;
      cnt = 0;
      do begin
         @(negedge clk);
         if (cnt == 0) begin
            chk("pcsrc", {63'd0, pcsrc}, {63'd0, br & zr & ~memop});
            chk("branch_target", branch_target, ams ? alu : adder);
         end
         s = stall;
         @(posedge clk);
         cnt++;
      end while (s && cnt < 40);
      #1;
      chk("occupancy", 64'(cnt), 64'(exp_cnt));
   endtask

   task automatic nop_inputs();
      rd = '0; result_out_alu = '0; Adderout = '0; writedata_out = '0;
      Branch = 0; zero = 0; Memread = 0; Memtoreg = 0; Memwrite = 0;
      Regwrite = 0; addermuxselect = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      logic mr, mw;
      nop_inputs();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_arr[i] = {$urandom, $urandom};
         ref_mem[i] = mem_arr[i];
      end
      mem_arr[0] = 64'hDEAD;
      ref_mem[0] = 64'hDEAD;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dmem_req",  {63'd0, dmem_req}, 64'd0);
      chk("rst_dmem_addr", dmem_addr, 64'd0);
      chk("rst_wb_read",   wb_readdata, 64'd0);
      chk("rst_wb_rd",     {59'd0, wb_rd}, 64'd0);
      chk("rst_stall",     {63'd0, stall}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      mon_on = 1'b1; resp_on = 1'b1;

      // ALU op, load with late ack, store with immediate ack, branches
      issue(5'd5, 64'h10, 64'h0, 64'h0, 0, 0, 0, 0, 0, 1, 0, 0);
      issue(5'd3, 64'h100, 64'h0, 64'h0, 0, 0, 1, 1, 0, 1, 0, 2);
      issue(5'd0, 64'h8, 64'h0, 64'h55, 0, 0, 0, 0, 1, 0, 0, 0);
      issue(5'd0, 64'h40, 64'h2000, 64'h0, 1, 1, 0, 0, 0, 0, 0, 0);
      issue(5'd1, 64'h3000, 64'h2000, 64'h0, 1, 1, 0, 0, 0, 1, 1, 0);
      issue(5'd2, 64'h3000, 64'h2000, 64'h0, 1, 0, 0, 0, 0, 1, 0, 0);
      issue(5'd4, 64'h8, 64'h0, 64'h0, 1, 1, 1, 1, 0, 1, 0, 1);

      // Randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         mr = ($urandom_range(2) == 0);
         mw = ($urandom_range(3) == 0);
         issue(5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom), 1'($urandom), mr, 1'($urandom), mw, 1'($urandom), 1'($urandom),
               int'($urandom_range(3)));
      end
      nop_inputs();
      mon_on = 1'b0;
      repeat (2) @(posedge clk);
      chk("wb_q_drained",  64'(wb_q.size()), 64'd0);
      chk("acc_q_drained", 64'(acc_q.size()), 64'd0);

      // Reset in the middle of an access, then a stray ack
      resp_on = 1'b0;
      @(posedge clk); #1;
      Memread = 1'b1; Memtoreg = 1'b1; result_out_alu = 64'h100;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (dmem_req !== 1'b1 && cnt < 10);
      chk("req_before_reset", {63'd0, dmem_req}, 64'd1);
      #1 reset = 1'b0;
      #1;
      chk("reset_req_drop",   {63'd0, dmem_req}, 64'd0);
      chk("reset_stall_drop", {63'd0, stall}, 64'd0);
      chk("reset_wb_memtoreg", {63'd0, wb_memtoreg}, 64'd0);
      nop_inputs();
      @(negedge clk);
      reset = 1'b1;
      dmem_rdata = 64'hBEEF;
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("late_ack_req",    {63'd0, dmem_req}, 64'd0);
      chk("late_ack_wbdata", wb_readdata, 64'd0);
      chk("late_ack_stall",  {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      mon_on = 1'b1; resp_on = 1'b1;
      // A fresh load still works and reads the unchanged memory
      issue(5'd7, 64'h100, 64'h0, 64'h0, 0, 0, 1, 1, 0, 1, 0, 1);
      nop_inputs();
      mon_on = 1'b0;
      repeat (2) @(posedge clk);
      chk("final_wb_q", 64'(wb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_memory_access_stage
`default_nettype wire

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter: XLEN, 64, datapath and address width.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: Adderout  in  XLEN  branch target from EX/MEM register.
REQ-005 SHALL have port: zero  in  1  ALU zero flag from EX/MEM.
REQ-006 SHALL have port: result_out_alu  in  XLEN  ALU result; memory address or writeback value.
REQ-007 SHALL have port: writedata_out  in  XLEN  store data.
REQ-008 SHALL have port: rd  in  5  destination register.
REQ-009 SHALL have port: Branch, Memread, Memtoreg, Memwrite, Regwrite, addermuxselect  in  1 each  control bits from EX/MEM.
REQ-010 SHALL have port: dmem_req  out  1  data-memory request, held until ack.
REQ-011 SHALL have port: dmem_we  out  1  1 = write, 0 = read.
REQ-012 SHALL have port: dmem_addr  out  XLEN  doubleword address.
REQ-013 SHALL have port: dmem_wdata  out  XLEN  store data.
REQ-014 SHALL have port: dmem_rdata  in  XLEN  load data, valid with ack.
REQ-015 SHALL have port: dmem_ack  in  1  one-cycle completion pulse.
REQ-016 SHALL have port: stall  out  1  hold all upstream stages, including the EX/MEM register.
REQ-017 SHALL have port: pcsrc  out  1  branch taken; also flush for IF/ID, ID/EX, EX/MEM.
REQ-018 SHALL have port: branch_target  out  XLEN  redirect PC.
REQ-019 SHALL have port: wb_readdata, wb_aluresult  out  XLEN each  MEM/WB data.
REQ-020 SHALL have port: wb_rd  out  5; wb_regwrite, wb_memtoreg  out  1 each  MEM/WB control.

Function
REQ-021 SHALL define mem_op = Memread | Memwrite; if both are set, the access SHALL be a write.
REQ-022 SHALL implement FSM IDLE, ACCESS, DONE:
- IDLE→ACCESS when mem_op.
- ACCESS→DONE on the edge where dmem_ack=1.
- DONE→IDLE unconditionally.
REQ-023 SHALL drive stall = (IDLE & mem_op) | ACCESS, combinationally; stall SHALL be 0 in DONE.
REQ-024 SHALL assert dmem_req only in ACCESS, with dmem_addr = result_out_alu, dmem_we = Memwrite, and dmem_wdata = writedata_out, all stable while the request is held.
REQ-025 SHALL ignore dmem_ack outside ACCESS; an ack on the first ACCESS cycle SHALL be legal, giving a minimum memory-op occupancy of 3 cycles (IDLE, ACCESS, DONE).
REQ-026 SHALL capture dmem_rdata into an internal load register on an acked read.
REQ-027 SHALL update the MEM/WB outputs on each edge where stall=0:
- wb_aluresult = result_out_alu, wb_rd = rd, wb_regwrite = Regwrite, wb_memtoreg = Memtoreg.
- wb_readdata = the load register for a read; 0 otherwise.
REQ-028 SHALL give non-memory instructions 1-cycle latency and SHALL not alter the MEM/WB outputs while stall=1.
REQ-029 SHALL drive pcsrc = Branch & zero & ~stall, combinationally.
REQ-030 SHALL drive branch_target = result_out_alu when addermuxselect=1 (jalr), else Adderout.
REQ-031 SHALL leave dmem_addr[2:0] unchecked; alignment is the producer's responsibility.

Reset
REQ-032 SHALL, on reset low, immediately force: FSM=IDLE; dmem_req, dmem_we = 0; dmem_addr, dmem_wdata = 0; load register = 0; all wb_* = 0.
REQ-033 SHALL abandon an in-flight access on reset mid-operation, with no retry; a late ack after release SHALL be ignored.

Structure
REQ-034 SHALL place the FSM state enum, XLEN and REG_ADDR_W=5 in shared package mem_stage_pkg.
REQ-035 SHALL implement the MEM/WB register as sub-module reg_memory_writeback, with enable = ~stall.

Verification
REQ-036 SHALL cover ALU op: Regwrite=1, rd=5, result_out_alu=0x10 -> next edge wb_rd=5, wb_aluresult=0x10, stall never high.
REQ-037 SHALL cover load with ack on 3rd ACCESS cycle: Memread=1, addr 0x100, rdata 0xDEAD -> stall high 4 cycles, then wb_readdata=0xDEAD, wb_memtoreg per input.
REQ-038 SHALL cover store with immediate ack: Memwrite=1, data 0x55 -> dmem_we=1, dmem_wdata=0x55 for 1 cycle, stall high 2 cycles, wb_readdata=0.
REQ-039 SHALL cover branches:
- Branch=1, zero=1, Adderout=0x2000 -> pcsrc=1, branch_target=0x2000.
- With addermuxselect=1 -> branch_target=result_out_alu.
REQ-040 SHALL cover reset in ACCESS: assert reset low -> dmem_req and stall drop that cycle; after release, a spurious ack produces no wb update.
